cls_update_scheduler: RTL
=========================

CLS_UPDATE_SCHEDULER -- requirements
Module: cls_update_scheduler

Interface
REQ-001 Parameters SHALL be:
  - parm_fast_simulation, 0, shortens the refresh period.
  - FCLK_ce, 2500000, i_spi_ce_4x rate in Hz.
  - parm_refresh_ms, 1000, periodic line rewrite period in ms; 0 disables refresh.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - i_ext_spi_clk_x, in, 1, sole clock.
  - i_srst, in, 1, reset; synchronous and active-high.
  - i_spi_ce_4x, in, 1, clock enable; the FSM and refresh timer advance only when it is high.
  - i_req_clear, in, 1, clear-display request pulse.
  - i_req_line1, in, 1, write-line-1 request pulse.
  - i_req_line2, in, 1, write-line-2 request pulse.
  - i_dat_line1, in, 128, line 1 text; 16 ASCII bytes, MSB byte first; sampled with i_req_line1.
  - i_dat_line2, in, 128, line 2 text; sampled with i_req_line2.
  - o_busy, out, 1, any request pending or a command in flight.
  - o_pending, out, 3, {clear, line1, line2} pending flags.
  - i_command_ready, in, 1, LCD driver idle/ready.
  - o_cmd_wr_clear_display, out, 1, driver command strobe.
  - o_cmd_wr_text_line1, out, 1, driver command strobe.
  - o_cmd_wr_text_line2, out, 1, driver command strobe.
  - o_dat_ascii_line1, out, 128, text presented to the driver.
  - o_dat_ascii_line2, out, 128, text presented to the driver.

Function
REQ-003 Request capture SHALL occur on every clock edge regardless of i_spi_ce_4x, so that single-clock pulses are never lost.
REQ-004 A line request SHALL set that line's pending flag and copy its i_dat_line* into a shadow register.
  - Latest data wins.
  - Repeated requests coalesce into one command.
REQ-005 The FSM SHALL have exactly four states: ST_IDLE, ST_ISSUE, ST_WAIT_ACCEPT, ST_WAIT_DONE.
REQ-006 From ST_IDLE, on a ce cycle with any pending flag set and i_command_ready=1, the FSM SHALL move to ST_ISSUE.
  - Target selection is fixed priority: clear > line1 > line2.
  - The target is latched at this transition.
REQ-007 In ST_ISSUE, for exactly one ce cycle:
  - Exactly one command strobe SHALL be high.
  - A line command SHALL copy the shadow to o_dat_ascii_line* on entry.
  - The target's pending flag SHALL be cleared.
  - The next state is ST_WAIT_ACCEPT.
REQ-008 ST_WAIT_ACCEPT SHALL go to ST_WAIT_DONE when i_command_ready=0.
REQ-009 ST_WAIT_ACCEPT SHALL also time out: after 8 ce cycles with ready still high, it goes to ST_IDLE and re-sets the target's pending flag (retry).
REQ-010 ST_WAIT_DONE SHALL return to ST_IDLE when i_command_ready=1.
REQ-011 Command strobes SHALL be zero in every state other than ST_ISSUE.
REQ-012 o_dat_ascii_line* SHALL stay unchanged from ST_ISSUE until the next ST_ISSUE of the same line.
REQ-013 A same-line request arriving in the clearing cycle of REQ-007 SHALL win, leaving the flag set; the new data goes to the shadow only.
REQ-014 The refresh timer SHALL count ce cycles with terminal count (FCLK_ce/1000 × parm_refresh_ms) − 1.
  - parm_fast_simulation=1 SHALL divide the terminal count by 100.
  - At terminal count the timer SHALL set the line1 and line2 pending flags and wrap to 0.
  - The timer runs in every state.
REQ-015 The refresh timer width SHALL be 24 bits; its terminal count SHALL saturate at 2^24−1.
REQ-016 A clear SHALL NOT alter the shadow registers or the line pending flags.
REQ-017 o_busy SHALL be (|o_pending) OR (state≠ST_IDLE), combinational from registers.
REQ-018 Minimum latency from a request pulse (ready high, FSM idle) to its strobe SHALL be 2 ce cycles; the strobe is glitch-free.

Reset
REQ-019 While i_srst=1 at a clock edge, regardless of i_spi_ce_4x:
  - The state SHALL go to ST_IDLE.
  - Pending flags, strobes, the refresh timer and the timeout counter SHALL go to 0.
  - Shadow and output text registers SHALL go to 16×8'h20 (spaces).
REQ-020 Reset asserted mid-command SHALL abandon the command with no retry.
REQ-021 Requests coincident with reset SHALL be discarded.

Structure
REQ-022 The shared package cls_sched_pkg SHALL hold:
  - the state enum t_cls_sched_state;
  - ASCII_SPACE (8'h20);
  - the target encoding (clear/line1/line2);
  - the timeout constant 8.
REQ-023 The refresh timer SHALL be one sub-module, cls_refresh_timer (ce-gated counter with terminal pulse).
REQ-024 There SHALL be no other sub-modules.

Verification
REQ-025 Single request: ready=1, pulse i_req_line1 with data "HELLO WORLD 0001" -> one o_cmd_wr_text_line1 strobe 2 ce after the pulse; o_dat_ascii_line1 equals the data; o_pending=3'b000 afterwards.
REQ-026 Simultaneous requests: pulse all three requests in the same clock -> strobes in order clear, line1, line2, each issued only after ready has fallen and risen again.
REQ-027 Coalescing: pulse i_req_line2 with "A" then "B" while busy on line1 -> exactly one line2 strobe, carrying "B".
REQ-028 Accept timeout: ready held at 1 with no drop -> return to ST_IDLE after 8 ce; the flag is re-set; the strobe is re-issued.
REQ-029 Refresh: parm_fast_simulation=1, parm_refresh_ms=100 -> line1 then line2 strobes every 2500 ce with unchanged text.
REQ-030 Reset mid-command: i_srst asserted in ST_WAIT_DONE -> all outputs at reset values next clock; no strobe after release until a new request.

Source files
------------

// File: rtl/cls_sched_pkg.sv
// Shared types and constants for the LCD update scheduler.
//   t_cls_sched_state : FSM state encoding
//   t_cls_target      : one-hot command target, bit-aligned with o_pending
//   ASCII_SPACE/TEXT_BLANK : reset value of the text registers
//   ACCEPT_TIMEOUT    : ce cycles to wait for the driver to take a strobe
//   refresh_tc()      : refresh terminal count, saturated to REFRESH_W bits
package cls_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE
  } t_cls_sched_state;

  localparam logic [7:0]   ASCII_SPACE = 8'h20;
  localparam logic [127:0] TEXT_BLANK  = {16{ASCII_SPACE}};

  // Target encoding matches o_pending = {clear, line1, line2}, so a target
  // can be OR'd into / masked out of the pending vector directly.
  typedef logic [2:0] t_cls_target;
  localparam t_cls_target TGT_NONE  = 3'b000;
  localparam t_cls_target TGT_LINE2 = 3'b001;
  localparam t_cls_target TGT_LINE1 = 3'b010;
  localparam t_cls_target TGT_CLEAR = 3'b100;

  localparam int ACCEPT_TIMEOUT = 8;
  localparam int TO_W           = $clog2(ACCEPT_TIMEOUT);

  localparam int     REFRESH_W   = 24;
  localparam longint REFRESH_MAX = 64'sd16777215;  // 2^24 - 1

  // (fclk/1000 * ms) - 1, optionally /100 for fast simulation, clamped.
  function automatic logic [REFRESH_W-1:0] refresh_tc(input int fclk_hz,
                                                      input int period_ms,
                                                      input bit fast);
    longint tc;
    tc = (longint'(fclk_hz) / 64'sd1000) * longint'(period_ms) - 64'sd1;
    if (fast) tc = tc / 64'sd100;
    if (tc < 64'sd0) tc = 64'sd0;
    if (tc > REFRESH_MAX) tc = REFRESH_MAX;
    return tc[REFRESH_W-1:0];
  endfunction

  // Fixed priority: clear > line1 > line2.
  function automatic t_cls_target pick_target(input logic [2:0] pend);
    if (pend[2])      return TGT_CLEAR;
    else if (pend[1]) return TGT_LINE1;
    else if (pend[0]) return TGT_LINE2;
    else              return TGT_NONE;
  endfunction

endpackage

// File: rtl/cls_update_scheduler_if.sv
// Request / LCD-driver bundle of the update scheduler.
//   master : request source and driver-ready side (drives i_*)
//   slave  : the scheduler (drives o_*)
interface cls_update_scheduler_if;
  logic         i_req_clear;
  logic         i_req_line1;
  logic         i_req_line2;
  logic [127:0] i_dat_line1;
  logic [127:0] i_dat_line2;
  logic         o_busy;
  logic [2:0]   o_pending;
  logic         i_command_ready;
  logic         o_cmd_wr_clear_display;
  logic         o_cmd_wr_text_line1;
  logic         o_cmd_wr_text_line2;
  logic [127:0] o_dat_ascii_line1;
  logic [127:0] o_dat_ascii_line2;

  modport master (
    output i_req_clear, i_req_line1, i_req_line2, i_dat_line1, i_dat_line2,
           i_command_ready,
    input  o_busy, o_pending, o_cmd_wr_clear_display, o_cmd_wr_text_line1,
           o_cmd_wr_text_line2, o_dat_ascii_line1, o_dat_ascii_line2
  );

  modport slave (
    input  i_req_clear, i_req_line1, i_req_line2, i_dat_line1, i_dat_line2,
           i_command_ready,
    output o_busy, o_pending, o_cmd_wr_clear_display, o_cmd_wr_text_line1,
           o_cmd_wr_text_line2, o_dat_ascii_line1, o_dat_ascii_line2
  );
endinterface

// File: rtl/cls_refresh_timer.sv
// Clock-enable gated free-running counter, 0..TC, with a one-ce terminal pulse.
//   clk, srst : clock, synchronous active-high reset
//   ce        : count enable
//   tick      : high on the ce cycle where the count sits at TC (then wraps)
// EN=0 freezes the counter and suppresses tick.
import cls_sched_pkg::*;

module cls_refresh_timer #(
  parameter bit                   EN = 1'b1,
  parameter logic [REFRESH_W-1:0] TC = '0
) (
  input  logic clk,
  input  logic srst,
  input  logic ce,
  output logic tick
);

  logic [REFRESH_W-1:0] cnt_q;

  assign tick = EN && ce && (cnt_q == TC);

  always_ff @(posedge clk) begin
    if (srst)           cnt_q <= '0;
    else if (EN && ce)  cnt_q <= (cnt_q == TC) ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/cls_update_scheduler.sv
// Serialises clear / line1 / line2 update requests onto a single LCD driver.
//   i_ext_spi_clk_x : clock
//   i_srst          : synchronous active-high reset
//   i_spi_ce_4x     : clock enable for the FSM and refresh timer
//   bus (slave)     : request pulses + text in, pending/busy status,
//                     one-ce command strobes and latched text to the driver
// Requests are captured on every clock (ce or not) into pending flags and
// shadow text; the FSM issues one command at a time, waits for the driver
// to drop ready (accept) and raise it again (done). No accept within
// ACCEPT_TIMEOUT ce cycles re-arms the request for a retry.
import cls_sched_pkg::*;

module cls_update_scheduler #(
  parameter int parm_fast_simulation = 0,
  parameter int FCLK_ce              = 2500000,
  parameter int parm_refresh_ms      = 1000
) (
  input  logic                   i_ext_spi_clk_x,
  input  logic                   i_srst,
  input  logic                   i_spi_ce_4x,
  cls_update_scheduler_if.slave  bus
);

  localparam bit                   REFRESH_EN = (parm_refresh_ms != 0);
  localparam logic [REFRESH_W-1:0] REFRESH_TC =
    refresh_tc(FCLK_ce, parm_refresh_ms, parm_fast_simulation != 0);

  t_cls_sched_state state_q, state_d;
  logic [2:0]       pend_q, pend_d;
  t_cls_target      tgt_q, tgt_d;
  logic [2:0]       strb_q, strb_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [127:0]     shd_line1_q, shd_line2_q;
  logic [127:0]     txt_line1_q, txt_line2_q;
  logic             refresh_tick;
  logic             issue_enter;

  cls_refresh_timer #(
    .EN (REFRESH_EN),
    .TC (REFRESH_TC)
  ) u_refresh (
    .clk  (i_ext_spi_clk_x),
    .srst (i_srst),
    .ce   (i_spi_ce_4x),
    .tick (refresh_tick)
  );

  // State register
  always_ff @(posedge i_ext_spi_clk_x) begin
    if (i_srst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; only moves on ce cycles
  always_comb begin
    state_d = state_q;
    if (i_spi_ce_4x) begin
      case (state_q)
        ST_IDLE:
          if ((|pend_q) && bus.i_command_ready) state_d = ST_ISSUE;
        ST_ISSUE:
          state_d = ST_WAIT_ACCEPT;
        ST_WAIT_ACCEPT:
          if (!bus.i_command_ready)                         state_d = ST_WAIT_DONE;
          else if (to_cnt_q == TO_W'(ACCEPT_TIMEOUT - 1))   state_d = ST_IDLE;
        ST_WAIT_DONE:
          if (bus.i_command_ready) state_d = ST_IDLE;
        default:
          state_d = ST_IDLE;
      endcase
    end
  end

  assign issue_enter = (state_q == ST_IDLE) && (state_d == ST_ISSUE);

  // Outputs / datapath next values
  always_comb begin
    tgt_d    = tgt_q;
    to_cnt_d = to_cnt_q;
    pend_d   = pend_q;
    if (i_spi_ce_4x) begin
      case (state_q)
        ST_IDLE:
          if (issue_enter) tgt_d = pick_target(pend_q);
        ST_ISSUE: begin
          pend_d   = pend_q & ~tgt_q;
          to_cnt_d = '0;
        end
        ST_WAIT_ACCEPT:
          if (bus.i_command_ready) begin
            if (state_d == ST_IDLE) pend_d = pend_q | tgt_q;  // retry
            else                    to_cnt_d = to_cnt_q + 1'b1;
          end
        default: ;
      endcase
    end
    // Set terms come last so a fresh request beats the ISSUE-cycle clear.
    if (refresh_tick)    pend_d = pend_d | TGT_LINE1 | TGT_LINE2;
    if (bus.i_req_clear) pend_d = pend_d | TGT_CLEAR;
    if (bus.i_req_line1) pend_d = pend_d | TGT_LINE1;
    if (bus.i_req_line2) pend_d = pend_d | TGT_LINE2;
    // Strobes are registered from next-state so they are glitch-free and
    // high exactly while the FSM sits in ST_ISSUE.
    strb_d = (state_d == ST_ISSUE) ? tgt_d : TGT_NONE;
  end

  always_ff @(posedge i_ext_spi_clk_x) begin
    if (i_srst) begin
      pend_q      <= '0;
      tgt_q       <= TGT_NONE;
      strb_q      <= '0;
      to_cnt_q    <= '0;
      shd_line1_q <= TEXT_BLANK;
      shd_line2_q <= TEXT_BLANK;
      txt_line1_q <= TEXT_BLANK;
      txt_line2_q <= TEXT_BLANK;
    end else begin
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      strb_q   <= strb_d;
      to_cnt_q <= to_cnt_d;
      if (bus.i_req_line1) shd_line1_q <= bus.i_dat_line1;
      if (bus.i_req_line2) shd_line2_q <= bus.i_dat_line2;
      // Presented text only changes on entry to ISSUE for that line.
      if (issue_enter && tgt_d == TGT_LINE1) txt_line1_q <= shd_line1_q;
      if (issue_enter && tgt_d == TGT_LINE2) txt_line2_q <= shd_line2_q;
    end
  end

  assign bus.o_pending              = pend_q;
  assign bus.o_busy                 = (|pend_q) || (state_q != ST_IDLE);
  assign bus.o_cmd_wr_clear_display = strb_q[2];
  assign bus.o_cmd_wr_text_line1    = strb_q[1];
  assign bus.o_cmd_wr_text_line2    = strb_q[0];
  assign bus.o_dat_ascii_line1      = txt_line1_q;
  assign bus.o_dat_ascii_line2      = txt_line2_q;

endmodule
